elevator_car_controller: RTL and testbench

//  Drives the left and right elevator cars. Consumes the hall calls and car destinations from
//  the people controller, and produces the per-car position word that controller reads back.

---
 rtl/elevator_car_controller.sv | 186 ++++++++++++++++++
 tb/tb_elevator_car_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_controller.sv
// Two independent elevator cars, each with a LOOK scheduler and an IDLE/MOVE/DOOR FSM.
// Positions advance in half-floor steps; a shared prescaler paces motion while the simulation runs.
module elevator_car_controller #(
   parameter int unsigned TICK_DIV    = 1048576,
   parameter int unsigned STEP_THRESH = 32,
   parameter int unsigned DOOR_TICKS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  simState,
   input  logic [2:0]  simSpeed,
   input  logic [11:0] floorsRequested,
   input  logic [11:0] floorDestinations,
   output logic [7:0]  elevatorStates,
   output logic [1:0]  doorOpen,
   output logic [1:0]  carDir,
   output logic [11:0] pendingFloors
);

   typedef enum logic [1:0] {SIM_START = 2'd0, SIM_RUN = 2'd1, SIM_PAUSE = 2'd2, SIM_ENDING = 2'd3} sim_state_e;
   typedef enum logic [1:0] {IDLE, MOVE, DOOR} car_state_e;

   localparam logic [6:0] THRESH    = 7'(STEP_THRESH);
   localparam logic [3:0] DOOR_LAST = 4'(DOOR_TICKS - 1);

   sim_state_e  sim_mode;
   logic        running;
   logic        latching;
   logic        tick;
   logic [19:0] presc_q;

   assign sim_mode = sim_state_e'(simState);
   assign running  = (sim_mode == SIM_RUN);
   assign latching = running || (sim_mode == SIM_PAUSE);
   assign tick     = running && (presc_q == 20'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc_q <= '0;
      else if (!latching)
         presc_q <= '0;
      else if (running)
         presc_q <= tick ? '0 : presc_q + 20'd1;
   end

   // Equal distance resolves downward, so up is chosen only when strictly closer.
   function automatic logic nearest_is_up(input logic [5:0] p, input logic [2:0] f);
      int unsigned fi;
      int unsigned dn;
      int unsigned up;
      fi = {29'd0, f};
      dn = 8;
      up = 8;
      for (int unsigned i = 0; i < 6; i++) begin
         if (p[i[2:0]]) begin
            if (i < fi && fi - i < dn) dn = fi - i;
            if (i > fi && i - fi < up) up = i - fi;
         end
      end
      return up < dn;
   endfunction

   function automatic logic any_ahead(input logic [5:0] p, input logic [2:0] f, input logic up);
      int unsigned fi;
      logic        found;
      fi    = {29'd0, f};
      found = 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (p[i[2:0]] && (up ? (i > fi) : (i < fi))) found = 1'b1;
      end
      return found;
   endfunction

   for (genvar c = 0; c < 2; c++) begin : g_car
      car_state_e state_q, state_d;
      logic [3:0] pos_q, pos_d, next_pos;
      logic [3:0] timer_q, timer_d;
      logic [5:0] prog_q, prog_d;
      logic [5:0] pend_q, pend_d;
      logic [5:0] req, clr;
      logic       dir_q, dir_d;
      logic [6:0] sum;
      logic [2:0] floor, next_floor;

      assign req = floorsRequested[6*c +: 6] | floorDestinations[6*c +: 6];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            prog_q  <= '0;
            timer_q <= '0;
            pend_q  <= '0;
         end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            prog_q  <= prog_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
         end
      end

      always_comb begin
         state_d    = state_q;
         pos_d      = pos_q;
         dir_d      = dir_q;
         prog_d     = prog_q;
         timer_d    = timer_q;
         pend_d     = pend_q;
         clr        = '0;
         sum        = {1'b0, prog_q} + {4'd0, simSpeed};
         floor      = pos_q[3:1];
         next_pos   = dir_q ? pos_q + 4'd1 : pos_q - 4'd1;
         next_floor = next_pos[3:1];
         if (!latching) begin
            state_d = IDLE;
            pos_d   = '0;
            dir_d   = 1'b1;
            prog_d  = '0;
            timer_d = '0;
            pend_d  = '0;
         end else begin
            if (tick) begin
               case (state_q)
                  IDLE: begin
                     if (pend_q[floor]) begin
                        state_d = DOOR;
                        timer_d = '0;
                        clr     = 6'b1 << floor;
                     end else if (|pend_q) begin
                        state_d = MOVE;
                        dir_d   = nearest_is_up(pend_q, floor);
                     end
                  end
                  MOVE: begin
                     if (dir_q && pos_q == 4'd10) begin
                        dir_d = 1'b0;
                     end else if (!dir_q && pos_q == 4'd0) begin
                        dir_d = 1'b1;
                     end else if (sum >= THRESH) begin
                        pos_d  = next_pos;
                        prog_d = 6'(sum - THRESH);
                        // Stop/reverse decisions only at whole floors; pend is the pre-latch value.
                        if (!next_pos[0]) begin
                           if (pend_q[next_floor]) begin
                              state_d = DOOR;
                              prog_d  = '0;
                              timer_d = '0;
                              clr     = 6'b1 << next_floor;
                           end else if (!any_ahead(pend_q, next_floor, dir_q)) begin
                              if (|pend_q) begin
                                 dir_d = !dir_q;
                              end else begin
                                 state_d = IDLE;
                                 prog_d  = '0;
                              end
                           end
                        end
                     end else begin
                        prog_d = sum[5:0];
                     end
                  end
                  DOOR: begin
                     if (timer_q == DOOR_LAST) begin
                        state_d = IDLE;
                        timer_d = '0;
                     end else begin
                        timer_d = timer_q + 4'd1;
                     end
                  end
                  default: state_d = IDLE;
               endcase
            end
            pend_d = (pend_q | req) & ~clr;
         end
      end

      assign elevatorStates[4*c +: 4] = pos_q;
      assign doorOpen[c]              = (state_q == DOOR);
      assign carDir[c]                = dir_q;
      assign pendingFloors[6*c +: 6]  = pend_q;
   end

endmodule

// File: tb/tb_elevator_car_controller.sv
// Randomized bench for elevator_car_controller against a floor-level behavioural model of both cars.
module tb_elevator_car_controller;

   localparam int TD = 4;
   localparam int ST = 32;
   localparam int DT = 4;
   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sim_state;
   logic [2:0]  sim_speed;
   logic [11:0] req;
   logic [11:0] dest;
   logic [7:0]  elevator_states;
   logic [1:0]  door_open;
   logic [1:0]  car_dir;
   logic [11:0] pending_floors;

   int checks   = 0;
   int failures = 0;

   int       m_pos[2];
   int       m_dir[2];
   int       m_prog[2];
   int       m_mode[2];
   int       m_door[2];
   bit [5:0] m_pend[2];
   int       m_cnt;

   always #5 clk = ~clk;

   elevator_car_controller #(
      .TICK_DIV(TD),
      .STEP_THRESH(ST),
      .DOOR_TICKS(DT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .simState(sim_state),
      .simSpeed(sim_speed),
      .floorsRequested(req),
      .floorDestinations(dest),
      .elevatorStates(elevator_states),
      .doorOpen(door_open),
      .carDir(car_dir),
      .pendingFloors(pending_floors)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit has(input bit [5:0] p, input int f);
      if (f < 0 || f > 5) return 1'b0;
      return ((p >> f) & 6'd1) != 6'd0;
   endfunction

   function automatic bit beyond(input bit [5:0] p, input int f, input int up);
      for (int k = 0; k < 6; k++)
         if (has(p, k) && ((up != 0) ? (k > f) : (k < f))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_pos[c]  = 0;
         m_dir[c]  = 1;
         m_prog[c] = 0;
         m_mode[c] = M_IDLE;
         m_door[c] = 0;
         m_pend[c] = '0;
      end
      m_cnt = 0;
   endtask

   // Predicts the state after the coming rising edge from the inputs currently driven.
   task automatic model_step();
      bit tick;
      if (rst || sim_state == 2'd0 || sim_state == 2'd3) begin
         model_reset();
         return;
      end
      tick = 1'b0;
      if (sim_state == 2'd1) begin
         if (m_cnt == TD - 1) begin
            tick  = 1'b1;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      for (int c = 0; c < 2; c++) begin
         bit [5:0] p;
         bit [5:0] clr;
         int       f;
         int       total;
         p   = m_pend[c];
         clr = '0;
         f   = m_pos[c] / 2;
         if (tick) begin
            if (m_mode[c] == M_IDLE) begin
               if (has(p, f)) begin
                  m_mode[c] = M_DOOR;
                  m_door[c] = DT;
                  clr       = 6'(1 << f);
               end else if (p != 0) begin
                  for (int d = 1; d <= 5; d++) begin
                     if (has(p, f - d)) begin m_dir[c] = 0; break; end
                     if (has(p, f + d)) begin m_dir[c] = 1; break; end
                  end
                  m_mode[c] = M_MOVE;
               end
            end else if (m_mode[c] == M_MOVE) begin
               if (m_dir[c] == 1 && m_pos[c] == 10) m_dir[c] = 0;
               else if (m_dir[c] == 0 && m_pos[c] == 0) m_dir[c] = 1;
               else begin
                  total = m_prog[c] + int'(sim_speed);
                  if (total >= ST) begin
                     m_prog[c] = total - ST;
                     m_pos[c]  = m_pos[c] + ((m_dir[c] == 1) ? 1 : -1);
                     if (m_pos[c] % 2 == 0) begin
                        f = m_pos[c] / 2;
                        if (has(p, f)) begin
                           m_mode[c] = M_DOOR;
                           m_door[c] = DT;
                           m_prog[c] = 0;
                           clr       = 6'(1 << f);
                        end else if (!beyond(p, f, m_dir[c])) begin
                           if (p != 0) m_dir[c] = 1 - m_dir[c];
                           else begin
                              m_mode[c] = M_IDLE;
                              m_prog[c] = 0;
                           end
                        end
                     end
                  end else begin
                     m_prog[c] = total;
                  end
               end
            end else begin
               m_door[c]--;
               if (m_door[c] == 0) m_mode[c] = M_IDLE;
            end
         end
         m_pend[c] = (p | req[6*c +: 6] | dest[6*c +: 6]) & ~clr;
      end
   endtask

   task automatic compare_all();
      check("pos", 32'(elevator_states), 32'({4'(m_pos[1]), 4'(m_pos[0])}));
      check("door", 32'(door_open), 32'({m_mode[1] == M_DOOR, m_mode[0] == M_DOOR}));
      check("dir", 32'(car_dir), 32'({m_dir[1][0], m_dir[0][0]}));
      check("pend", 32'(pending_floors), 32'({m_pend[1], m_pend[0]}));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic pulse(input logic [11:0] r, input logic [11:0] d);
      req  = r;
      dest = d;
      cycle();
      req  = '0;
      dest = '0;
   endtask

   initial begin
      int          n;
      int unsigned r;
      rst       = 1'b1;
      sim_state = 2'd1;
      sim_speed = 3'd4;
      req       = 12'h001;
      dest      = '0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check("rst_pos", 32'(elevator_states), 32'h0);
         check("rst_door", 32'(door_open), 32'h0);
         check("rst_pend", 32'(pending_floors), 32'h0);
         check("rst_dir", 32'(car_dir), 32'h3);
      end
      rst       = 1'b0;
      req       = '0;
      sim_state = 2'd0;
      cycle();

      sim_state = 2'd1;
      pulse(12'h008, 12'h000);
      for (int k = 0; k < 600 && !door_open[0]; k++) cycle();
      check("s1_door_seen", 32'(door_open[0]), 32'h1);
      check("s1_posL", 32'(elevator_states[3:0]), 32'h6);
      check("s1_pend3", 32'(pending_floors[3]), 32'h0);
      n = 1;
      for (int k = 0; k < 100; k++) begin
         cycle();
         if (!door_open[0]) break;
         n++;
      end
      check("s1_door_len", 32'(n), 32'd16);

      sim_speed = 3'd7;
      pulse(12'h000, 12'h020);
      for (int k = 0; k < 400 && elevator_states[3:0] != 4'd7; k++) cycle();
      check("pause_start_pos", 32'(elevator_states[3:0]), 32'h7);
      sim_state = 2'd2;
      repeat (100) cycle();
      check("pause_pos", 32'(elevator_states[3:0]), 32'h7);
      check("pause_door", 32'(door_open), 32'h0);
      sim_state = 2'd1;
      for (int k = 0; k < 400 && !door_open[0]; k++) cycle();
      check("resume_posL", 32'(elevator_states[3:0]), 32'hA);

      pulse(12'h401, 12'h000);
      repeat (40) cycle();
      sim_state = 2'd3;
      cycle();
      check("end_pos", 32'(elevator_states), 32'h0);
      check("end_pend", 32'(pending_floors), 32'h0);
      check("end_door", 32'(door_open), 32'h0);
      check("end_dir", 32'(car_dir), 32'h3);

      sim_state = 2'd1;
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 5) sim_state = (r < 2) ? 2'd3 : 2'd0;
         else if (r < 25) sim_state = 2'd2;
         else if (r < 120) sim_state = 2'd1;
         if (r % 97 == 0) sim_speed = 3'($urandom_range(0, 7));
         req  = ($urandom_range(0, 29) == 0) ? 12'(1 << $urandom_range(0, 11)) : '0;
         dest = ($urandom_range(0, 29) == 0) ? 12'(1 << $urandom_range(0, 11)) : '0;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
